// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents: 3-bit operation encodings, FSM state type, and a helper that tells
// whether an op runs through the iterative core.
// Optional feature macro: ALU_SEQ_MUL_EN (enables op=100 as a shift-add multiply).
package alu_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_POPCNT = 3'b011;
  localparam logic [2:0] OP_MUL    = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // True for ops that take the multi-cycle path through alu_iter_core.
  function automatic logic is_iter_op(logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
    return (op == OP_POPCNT) || (op == OP_MUL);
`else
    return (op == OP_POPCNT);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath shared by POPCNT and (optionally) MUL.
// Ports:
//   clk, rst   clock / synchronous active-high reset
//   load       capture a, b, mul; counter=WIDTH, accumulator=0
//   step       consume one bit of the shifted b operand
//   mul        1: shift-add multiply, 0: population count (sampled on load)
//   a, b       operands (a only matters for multiply)
//   last       the current step is the final one (counter==1)
//   sum        accumulator value after the current step, zero-extended to 2*WIDTH
// Optional feature macro: ALU_SEQ_MUL_EN; without it no multiplicand register or
// wide accumulator exists.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               mul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] sum
);

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned AccW = 2 * WIDTH;
`else
  localparam int unsigned AccW = WIDTH;
`endif

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [AccW-1:0]  acc_q, acc_d;

  assign last = (cnt_q == CNT_W'(1));
  assign sum  = (2 * WIDTH)'(acc_d);

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q;
  logic               mul_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mul_q   <= 1'b0;
    end else if (load) begin
      mcand_q <= {{WIDTH{1'b0}}, a};
      mul_q   <= mul;
    end else if (step) begin
      mcand_q <= mcand_q << 1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (mul_q) begin
      if (sreg_q[0]) acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q + AccW'(sreg_q[0]);
    end
  end
`else
  logic unused_mul;
  assign unused_mul = ^{mul, a};

  always_comb begin
    acc_d = acc_q + AccW'(sreg_q[0]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      acc_q  <= '0;
    end else if (load) begin
      cnt_q  <= CNT_W'(WIDTH);
      sreg_q <= b;
      acc_q  <= '0;
    end else if (step) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      sreg_q <= sreg_q >> 1;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   start         request, sampled only while busy=0
//   op            000 NOP, 001 ADD, 010 SUB, 011 POPCNT, 100 MUL (optional), else NOP
//   a, b          operands (register A side, bus side)
//   busy          operation in progress
//   done          one-cycle pulse; result/carry/zero valid from this cycle
//   result        registered result, held until the next done
//   carry         ADD carry-out / SUB borrow / MUL overflow, else 0
//   zero          result == 0
// Optional feature macro: ALU_SEQ_MUL_EN (op=100 becomes a WIDTH-cycle multiply).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic               iter_load, iter_step, iter_last;
  logic [2*WIDTH-1:0] iter_sum;

  alu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (iter_load),
    .step (iter_step),
    .mul  (op == OP_MUL),
    .a    (a),
    .b    (b),
    .last (iter_last),
    .sum  (iter_sum)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    done_d    = 1'b0;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    iter_load = 1'b0;
    iter_step = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d  = a;
          b_d  = b;
          op_d = op;
          if (is_iter_op(op)) begin
            iter_load = 1'b1;
            state_d   = S_ITER;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_ITER: begin
        iter_step = 1'b1;
        // The final step's sum goes straight into the output registers, so
        // done lands on the WIDTH-th edge after start.
        if (iter_last) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = iter_sum[WIDTH-1:0];
          carry_d  = (op_q == OP_MUL) && (|iter_sum[2*WIDTH-1:WIDTH]);
          zero_d   = (iter_sum[WIDTH-1:0] == '0);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_ADD:  {carry_d, result_d} = {1'b0, a_q} + {1'b0, b_q};
          OP_SUB: begin
            result_d = a_q - b_q;
            carry_d  = (a_q < b_q);
          end
          default: begin
            result_d = '0;
            carry_d  = 1'b0;
          end
        endcase
        zero_d = (result_d == '0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOP;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=9): vector table, random ops against a
// plain-arithmetic model, and hand-written busy-start / reset-abort sequences.
// Honours ALU_SEQ_MUL_EN for op=100 expectations.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W   = 9;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry, zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] last_res;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    int           lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions.
  task automatic model(input logic [2:0] o, input int unsigned av, input int unsigned bv,
                       output logic [W-1:0] res, output logic c, output int lat);
    longint unsigned p;
    int unsigned     ones;
    res = '0;
    c   = 1'b0;
    lat = 1;
    case (o)
      3'd1: begin
        p   = longint'(av) + longint'(bv);
        res = W'(p % MOD);
        c   = (p >= MOD);
      end
      3'd2: begin
        res = W'((av + MOD - bv) % MOD);
        c   = (av < bv);
      end
      3'd3: begin
        ones = 0;
        for (int i = 0; i < W; i++) ones += (bv >> i) & 1;
        res = W'(ones);
        lat = W;
      end
`ifdef ALU_SEQ_MUL_EN
      3'd4: begin
        p   = longint'(av) * longint'(bv);
        res = W'(p % MOD);
        c   = (p / MOD) != 0;
        lat = W;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] er, input logic ec,
                       input int el);
    int lat;
    bit got_done;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;  // edge k
    start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    check({name, " busy@k"}, busy, 1);
    check({name, " done@k"}, done, 0);
    lat = 0;
    got_done = 0;
    while (!got_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) got_done = 1;
      else begin
        check({name, " busy-mid"}, busy, 1);
        check({name, " result-held"}, result, last_res);
      end
    end
    check({name, " latency"}, lat, el);
    check({name, " result"}, result, er);
    check({name, " carry"}, carry, ec);
    check({name, " zero"}, zero, (er == '0));
    check({name, " busy@done"}, busy, 0);
    last_res = er;
    @(posedge clk); #1;
    check({name, " done-drop"}, done, 0);
    check({name, " result-after"}, result, er);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ec;
    int           el, lat, spurious;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst carry", carry, 0);
    check("rst zero", zero, 0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back('{OP_ADD,    9'h0FF, 9'h001, 9'h100, 1'b0, 1});
    tbl.push_back('{OP_ADD,    9'h1FF, 9'h001, 9'h000, 1'b1, 1});
    tbl.push_back('{OP_SUB,    9'h005, 9'h007, 9'h1FE, 1'b1, 1});
    tbl.push_back('{OP_SUB,    9'h007, 9'h005, 9'h002, 1'b0, 1});
    tbl.push_back('{OP_POPCNT, 9'h123, 9'h1FF, 9'h009, 1'b0, W});
    tbl.push_back('{OP_POPCNT, 9'h1FF, 9'h000, 9'h000, 1'b0, W});
    tbl.push_back('{OP_NOP,    9'h003, 9'h004, 9'h000, 1'b0, 1});
    tbl.push_back('{3'b111,    9'h1FF, 9'h1FF, 9'h000, 1'b0, 1});
`ifdef ALU_SEQ_MUL_EN
    tbl.push_back('{OP_MUL,    9'h010, 9'h011, 9'h110, 1'b0, W});
    tbl.push_back('{OP_MUL,    9'h100, 9'h002, 9'h000, 1'b1, W});
`else
    tbl.push_back('{OP_MUL,    9'h010, 9'h011, 9'h000, 1'b0, 1});
`endif

    for (int i = 0; i < tbl.size(); i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].c,
            tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      model(ro, ra, rb, er, ec, el);
      do_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, er, ec, el);
    end

    // Start during POPCNT is ignored; start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; op = OP_POPCNT; a = '0; b = 9'h0AB;
    @(posedge clk); #1;  // k
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 9'h001; b = 9'h1FF;
    @(posedge clk); #1;  // k+3
    start = 1'b0;
    check("ign busy@k+3", busy, 1);
    lat = 3;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign latency", lat, W);
    check("ign result", result, 5);
    start = 1'b1; op = OP_ADD; a = 9'h010; b = 9'h020;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b done@k", done, 0);
    check("b2b busy@k", busy, 1);
    @(posedge clk); #1;
    check("b2b done", done, 1);
    check("b2b result", result, 9'h030);
    check("b2b busy@done", busy, 0);

    // Reset in the middle of a POPCNT aborts it without a done.
    @(negedge clk);
    start = 1'b1; op = OP_POPCNT; b = 9'h1FF;
    @(posedge clk); #1;  // k
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;  // k+4
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) spurious++;
    end
    check("abort no-done", spurious, 0);
    last_res = '0;
    do_op("post-abort add", OP_ADD, 9'h003, 9'h004, 9'h007, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
